// File: rtl/led_breather.sv
// led_breather: tick-stepped PWM level ramp (rise, top hold, fall, bottom hold) driving an LED
// Ports: clock/reset (sync, active-high); tick = one-cycle slow-rate enable; enable = run (0 parks, LED off);
//        pwm_out = registered PWM drive; level = current brightness; rising = high in RISE/TOP_HOLD.
module led_breather #(
  parameter int PWM_BITS   = 8,
  parameter int STEP_TICKS = 4,
  parameter int HOLD_STEPS = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  input  logic                enable,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] level,
  output logic                rising
);
  localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [TW-1:0] T_LAST = TW'(STEP_TICKS - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_STEPS - 1);
  typedef enum logic [2:0] {IDLE, RISE, TOP_HOLD, FALL, BOTTOM_HOLD} state_t;
  state_t r_state, w_state;
  logic [PWM_BITS-1:0] r_pwm_cnt, r_level, w_level;
  logic [TW-1:0] r_tick_cnt, w_tick_cnt;
  logic [HW-1:0] r_hold_cnt, w_hold_cnt;
  logic r_pwm_out, r_rising, w_run, w_step, w_hold_done;
  assign pwm_out = r_pwm_out;
  assign level   = r_level;
  assign rising  = r_rising;
  always_comb begin
    w_run       = (r_state != IDLE) && enable;
    w_step      = w_run && tick && (r_tick_cnt == T_LAST);
    w_hold_done = r_hold_cnt == H_LAST;
    w_state     = r_state;
    w_level     = r_level;
    w_hold_cnt  = r_hold_cnt;
    w_tick_cnt  = (w_run && tick) ? (w_step ? '0 : r_tick_cnt + 1'b1) : r_tick_cnt;
    if (!enable) begin
      // dropping enable wins over any simultaneous step
      w_state    = IDLE;
      w_level    = '0;
      w_tick_cnt = '0;
      w_hold_cnt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state    = RISE;
          w_tick_cnt = '0;
          w_hold_cnt = '0;
        end
        RISE: if (w_step && r_level != MAX) begin
          w_level = r_level + 1'b1;
          w_state = (r_level == MAX - 1'b1) ? TOP_HOLD : RISE;
          w_hold_cnt = '0;
        end
        TOP_HOLD: if (w_step) begin
          w_state    = w_hold_done ? FALL : TOP_HOLD;
          w_hold_cnt = w_hold_done ? '0 : r_hold_cnt + 1'b1;
        end
        FALL: if (w_step && r_level != '0) begin
          w_level = r_level - 1'b1;
          w_state = (r_level == 1) ? BOTTOM_HOLD : FALL;
          w_hold_cnt = '0;
        end
        BOTTOM_HOLD: if (w_step) begin
          w_state    = w_hold_done ? RISE : BOTTOM_HOLD;
          w_hold_cnt = w_hold_done ? '0 : r_hold_cnt + 1'b1;
        end
        default: w_state = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pwm_cnt  <= '0;
      r_level    <= '0;
      r_tick_cnt <= '0;
      r_hold_cnt <= '0;
      r_pwm_out  <= 1'b0;
      r_rising   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_pwm_cnt  <= r_pwm_cnt + 1'b1;
      r_level    <= w_level;
      r_tick_cnt <= w_tick_cnt;
      r_hold_cnt <= w_hold_cnt;
      r_pwm_out  <= r_pwm_cnt < r_level;
      r_rising   <= (w_state == RISE) || (w_state == TOP_HOLD);
    end
  end
endmodule

// File: tb/tb_led_breather.sv
// tb_led_breather: directed checks of led_breather with PWM_BITS=3, STEP_TICKS=2, HOLD_STEPS=2
module tb_led_breather;
  logic clock = 1'b0, reset = 1'b1, tick = 1'b0, enable = 1'b0;
  logic pwm_out, rising;
  logic [2:0] level;
  int total = 0, bad = 0;
  led_breather #(.PWM_BITS(3), .STEP_TICKS(2), .HOLD_STEPS(2)) dut (
    .clock(clock), .reset(reset), .tick(tick), .enable(enable),
    .pwm_out(pwm_out), .level(level), .rising(rising)
  );
  always #5 clock = ~clock;
  typedef struct {
    int         n;
    logic [2:0] lvl;
    logic       rise;
  } vec_t;
  vec_t tbl[14];
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  initial begin
    int highs;
    logic seen4;
    tbl[0]  = '{1, 3'd0, 1'b1};
    tbl[1]  = '{1, 3'd1, 1'b1};
    tbl[2]  = '{11, 3'd6, 1'b1};
    tbl[3]  = '{1, 3'd7, 1'b1};
    tbl[4]  = '{2, 3'd7, 1'b1};
    tbl[5]  = '{2, 3'd7, 1'b0};
    tbl[6]  = '{2, 3'd6, 1'b0};
    tbl[7]  = '{11, 3'd1, 1'b0};
    tbl[8]  = '{1, 3'd0, 1'b0};
    tbl[9]  = '{2, 3'd0, 1'b0};
    tbl[10] = '{2, 3'd0, 1'b1};
    tbl[11] = '{2, 3'd1, 1'b1};
    tbl[12] = '{2, 3'd2, 1'b1};
    tbl[13] = '{6, 3'd5, 1'b1};
    // reset dominates enable and tick
    reset = 1'b1; enable = 1'b1; tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_pwm", pwm_out, 0);
      chk("rst_level", level, 0);
      chk("rst_rising", rising, 0);
    end
    reset = 1'b0; tick = 1'b0;
    cyc();
    chk("enter_rise", rising, 1);
    // full breathing cycle, tick every clock
    tick = 1'b1;
    for (int v = 0; v < 14; v++) begin
      for (int k = 0; k < tbl[v].n; k++) cyc();
      chk($sformatf("ramp_level[%0d]", v), level, tbl[v].lvl);
      chk($sformatf("ramp_rising[%0d]", v), rising, tbl[v].rise);
    end
    // duty at level 5
    tick = 1'b0;
    cyc(); cyc();
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      highs += int'(pwm_out);
    end
    chk("duty5_highs", highs, 5);
    chk("duty5_level", level, 5);
    // zero level: no ticks, pwm stays low
    reset = 1'b1;
    cyc();
    reset = 1'b0; enable = 1'b1; tick = 1'b0;
    highs = 0;
    for (int i = 0; i < 64; i++) begin
      cyc();
      highs += int'(pwm_out);
    end
    chk("zero_highs", highs, 0);
    chk("zero_level", level, 0);
    // abort mid-ramp on the step-completing tick at level 3
    tick = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    chk("abort_pre_level", level, 3);
    cyc();
    enable = 1'b0;
    cyc();
    tick = 1'b0;
    chk("abort_level", level, 0);
    chk("abort_rising", rising, 0);
    cyc();
    chk("abort_pwm", pwm_out, 0);
    // ignored ticks while disabled
    seen4 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick = (i % 2 == 0);
      cyc();
      seen4 |= (level == 3'd4);
      if (i % 8 == 7) begin
        chk("idle_level", level, 0);
        chk("idle_pwm", pwm_out, 0);
        chk("idle_rising", rising, 0);
      end
    end
    chk("abort_no_level4", seen4, 0);
    // re-enable with tick held: transition tick not counted
    enable = 1'b1; tick = 1'b1;
    cyc();
    chk("reen_rising", rising, 1);
    chk("reen_level0", level, 0);
    cyc();
    chk("reen_level_tick1", level, 0);
    cyc();
    chk("reen_level_tick2", level, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
